// File: rtl/rotating_lane_buffer_pkg.sv
// +----------------------------------------------------------------------------
// | rotating_lane_buffer_pkg
// | Default geometry shared by the lane buffer and its crossbar.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package rotating_lane_buffer_pkg;

  localparam int RLB_DEFAULT_NUM_DATA   = 4;
  localparam int RLB_DEFAULT_DATA_WIDTH = 8;

endpackage : rotating_lane_buffer_pkg

`default_nettype wire

// File: rtl/rotating_lane_buffer_xbar.sv
// +----------------------------------------------------------------------------
// | rotating_xbar
// | Rotates NUM_DATA slot entries so that output lane j = slot (start + j).
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module rotating_xbar
  import rotating_lane_buffer_pkg::*;
#(
  parameter int NUM_DATA   = RLB_DEFAULT_NUM_DATA,
  parameter int DATA_WIDTH = RLB_DEFAULT_DATA_WIDTH
) (
  input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
  input  logic [$clog2(NUM_DATA)-1:0]    start_select_i,
  output logic [NUM_DATA*DATA_WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(NUM_DATA);

  logic [DATA_WIDTH-1:0] w_slot [NUM_DATA];

  for (genvar s = 0; s < NUM_DATA; s++) begin : g_unpack
    assign w_slot[s] = data_i[s*DATA_WIDTH +: DATA_WIDTH];
  end

  // The IDX_W-bit sum wraps naturally, giving the modulo for free.
  for (genvar j = 0; j < NUM_DATA; j++) begin : g_lane
    logic [IDX_W-1:0] w_sel;
    assign w_sel = start_select_i + IDX_W'(j);
    assign data_o[j*DATA_WIDTH +: DATA_WIDTH] = w_slot[w_sel];
  end

endmodule : rotating_xbar

`default_nettype wire

// File: rtl/rotating_lane_buffer.sv
// +----------------------------------------------------------------------------
// | rotating_lane_buffer
// | Circular buffer presenting held entries oldest-first on NUM_DATA lanes,
// | one push and any number of pops per cycle.
// | Optional: ROTATING_LANE_BUFFER_FLUSH_EN adds flush_i (clears head/count).
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module rotating_lane_buffer
  import rotating_lane_buffer_pkg::*;
#(
  parameter int NUM_DATA   = RLB_DEFAULT_NUM_DATA,
  parameter int DATA_WIDTH = RLB_DEFAULT_DATA_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             arst_ni,
`ifdef ROTATING_LANE_BUFFER_FLUSH_EN
  input  logic                             flush_i,
`endif
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic                             data_valid_i,
  output logic                             data_ready_o,
  output logic [NUM_DATA*DATA_WIDTH-1:0]   data_o,
  output logic [NUM_DATA-1:0]              data_valid_o,
  input  logic [$clog2(NUM_DATA+1)-1:0]    pop_count_i,
  output logic [$clog2(NUM_DATA+1)-1:0]    count_o
);

  localparam int IDX_W = $clog2(NUM_DATA);
  localparam int CNT_W = $clog2(NUM_DATA + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t C_FULL = cnt_t'(NUM_DATA);

  idx_t                           r_head;
  cnt_t                           r_count;
  logic                           w_flush;
  logic                           w_push;
  cnt_t                           w_pop_eff;
  idx_t                           w_tail;
  logic [NUM_DATA*DATA_WIDTH-1:0] w_mem_flat;

`ifdef ROTATING_LANE_BUFFER_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Ready looks only at the registered count, so a pop never frees room
  // for a push in the same cycle.
  assign data_ready_o = (r_count != C_FULL) && !w_flush;
  assign w_push       = data_valid_i && data_ready_o;
  assign w_pop_eff    = (pop_count_i > r_count) ? r_count : pop_count_i;
  assign w_tail       = r_head + r_count[IDX_W-1:0];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_head  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_eff[IDX_W-1:0];
      r_count <= r_count - w_pop_eff + cnt_t'(w_push);
    end
  end

  // Slots are never cleared on pop; stale contents sit behind data_valid_o.
  for (genvar s = 0; s < NUM_DATA; s++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot;

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        r_slot <= '0;
      end else if (w_push && (w_tail == idx_t'(s))) begin
        r_slot <= data_i;
      end
    end

    assign w_mem_flat[s*DATA_WIDTH +: DATA_WIDTH] = r_slot;
    assign data_valid_o[s] = (r_count > cnt_t'(s));
  end

  rotating_xbar #(
    .NUM_DATA   (NUM_DATA),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_xbar (
    .data_i         (w_mem_flat),
    .start_select_i (r_head),
    .data_o         (data_o)
  );

  assign count_o = r_count;

endmodule : rotating_lane_buffer

`default_nettype wire
